// File: rtl/window_stream_gen.sv
// Raster-scan KxK window generator with K-1 line buffers and a single valid/ready output register.
// Optional macro WIN_BORDER_ZERO_EN: emit a window for every pixel, zeroing taps that fall outside the frame.
module window_stream_gen #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_sof,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [K*K*(DATA_W+1)-1:0]  out_win,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int TW = DATA_W + 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  logic [DATA_W-1:0]      r_lb  [K-1][IMG_W];
  logic [DATA_W-1:0]      r_win [K][K];
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [K*K*TW-1:0]      r_out_win;

  logic [CW-1:0]          w_col;
  logic [RW-1:0]          w_row;
  logic [DATA_W-1:0]      w_colv [K];
  logic [DATA_W-1:0]      w_nwin [K][K];
  logic [K*K*TW-1:0]      w_flat;
  logic                   w_accept;
  logic                   w_elig;
  logic                   w_last;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A start-of-frame pixel overrides whatever the counters hold.
  assign w_col     = in_sof ? '0 : r_col;
  assign w_row     = in_sof ? '0 : r_row;
  assign w_last    = (w_row == RW'(IMG_H-1)) && (w_col == CW'(IMG_W-1));

`ifdef WIN_BORDER_ZERO_EN
  assign w_elig = 1'b1;
`else
  assign w_elig = (w_row >= RW'(K-1)) && (w_col >= CW'(K-1));
`endif

  for (genvar gi = 0; gi < K-1; gi++) begin : g_colv
    assign w_colv[gi] = r_lb[K-2-gi][w_col];
  end
  assign w_colv[K-1] = in_data;

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_tap
      logic [DATA_W-1:0] w_tap;
      if (gj == K-1) begin : g_new
        assign w_nwin[gi][gj] = w_colv[gi];
      end else begin : g_shift
        assign w_nwin[gi][gj] = r_win[gi][gj+1];
      end
`ifdef WIN_BORDER_ZERO_EN
      // Mask from the live counters so stale register/buffer data never leaks out.
      assign w_tap = ((int'(w_row) + gi < K-1) || (int'(w_col) + gj < K-1)) ?
                     '0 : w_nwin[gi][gj];
`else
      assign w_tap = w_nwin[gi][gj];
`endif
      assign w_flat[(gi*K+gj)*TW +: TW] = {1'b0, w_tap};
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][w_col] <= in_data;
      for (int i = 1; i < K-1; i++) begin
        r_lb[i][w_col] <= r_lb[i-1][w_col];
      end
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_win   <= '0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else begin
      if (w_accept) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K; j++) begin
            r_win[i][j] <= w_nwin[i][j];
          end
        end
        if (w_col == CW'(IMG_W-1)) begin
          r_col <= '0;
          r_row <= (w_row == RW'(IMG_H-1)) ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
      if (w_accept && w_elig) begin
        r_out_valid <= 1'b1;
        r_out_win   <= w_flat;
        r_out_last  <= w_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_win   = r_out_win;

endmodule
